// File: rtl/inst_fetch_port.sv
// Instruction-side RAM responder: 4 byte reads per fetch, little-endian word assembly, one-cycle inst_ok.
// Optional one-entry next-word prefetch buffer enabled by defining IF_PREFETCH_EN.
module inst_fetch_port #(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              inst_fe,
  input  logic [ADDR_W-1:0] inst_fpc,
  output logic [31:0]       inst_o,
  output logic              inst_ok,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [7:0]        mem_din,
  output logic              mem_wr
);

`ifdef IF_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, FETCH, DONE, PREF} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
`endif

  state_t              state;
  logic [ADDR_W-1:0]   base;
  logic [2:0]          iss_cnt;
  logic                iss_vld;
  logic [RAM_LAT-1:0]  pipe;
  logic [1:0]          cap_cnt;
  logic [23:0]         word;
  logic                abort_q;

  logic busy, flush, cap, last, hit, start, deliver;

`ifdef IF_PREFETCH_EN
  logic [ADDR_W-1:0] pf_pc;
  logic [31:0]       pf_word;
  logic              pf_valid;
  logic              wait_gnt;
  logic              promote;
`endif

  assign mem_wr = 1'b0;

  always_comb begin
    busy  = (state == FETCH);
    flush = busy && (!inst_fe || inst_fpc != base);
    hit   = 1'b0;
`ifdef IF_PREFETCH_EN
    hit     = (state == IDLE) && !abort_q && inst_fe && pf_valid && (inst_fpc == pf_pc);
    promote = (state == PREF) && inst_fe && (inst_fpc == base);
    if (state == PREF) begin
      busy  = 1'b1;
      flush = inst_fe && (inst_fpc != base);
    end
`endif
    cap     = busy && pipe[RAM_LAT-1];
    last    = cap && (cap_cnt == 2'd3);
`ifdef IF_PREFETCH_EN
    deliver = last && ((state == FETCH) || promote);
`else
    deliver = last;
`endif
    start   = (state == IDLE) && !abort_q && inst_fe && mem_gnt && !hit;
    // Held low for one cycle after an abort so the arbiter sees the release.
    mem_req = rst_n && (busy || ((state == IDLE) && inst_fe && !abort_q && !hit));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base    <= '0;
      iss_cnt <= '0;
      iss_vld <= 1'b0;
      pipe    <= '0;
      cap_cnt <= '0;
      word    <= '0;
      abort_q <= 1'b0;
      inst_o  <= '0;
      inst_ok <= 1'b0;
      inst_pc <= '0;
      mem_a   <= '0;
`ifdef IF_PREFETCH_EN
      pf_pc    <= '0;
      pf_word  <= '0;
      pf_valid <= 1'b0;
      wait_gnt <= 1'b0;
`endif
    end else if (rdy) begin
      // pipe[i] marks that the address issued i+1 cycles ago returns data now.
      pipe <= RAM_LAT'({pipe, iss_vld});
      case (state)
        IDLE: begin
          abort_q <= 1'b0;
`ifdef IF_PREFETCH_EN
          if (hit) begin
            inst_ok  <= 1'b1;
            inst_o   <= pf_word;
            inst_pc  <= pf_pc;
            base     <= pf_pc;
            pf_valid <= 1'b0;
            state    <= DONE;
          end else
`endif
          if (start) begin
            base    <= inst_fpc;
            mem_a   <= inst_fpc;
            iss_cnt <= 3'd1;
            iss_vld <= 1'b1;
            cap_cnt <= 2'd0;
            state   <= FETCH;
          end
        end
        DONE: begin
          inst_ok <= 1'b0;
          state   <= IDLE;
`ifdef IF_PREFETCH_EN
          if (!inst_fe || inst_fpc == base + ADDR_W'(4)) begin
            state    <= PREF;
            base     <= base + ADDR_W'(4);
            wait_gnt <= 1'b1;
            iss_cnt  <= 3'd0;
            cap_cnt  <= 2'd0;
          end
`endif
        end
        default: begin
          if (flush) begin
            state   <= IDLE;
            mem_a   <= '0;
            iss_vld <= 1'b0;
            pipe    <= '0;
            abort_q <= 1'b1;
`ifdef IF_PREFETCH_EN
            if (state == PREF) pf_valid <= 1'b0;
`endif
          end else begin
`ifdef IF_PREFETCH_EN
            if (wait_gnt) begin
              if (mem_gnt) begin
                wait_gnt <= 1'b0;
                mem_a    <= base;
                iss_cnt  <= 3'd1;
                iss_vld  <= 1'b1;
              end
            end else
`endif
            if (iss_cnt != 3'd4) begin
              mem_a   <= base + ADDR_W'(iss_cnt);
              iss_cnt <= iss_cnt + 3'd1;
              iss_vld <= 1'b1;
            end else begin
              mem_a   <= '0;
              iss_vld <= 1'b0;
            end
            if (cap) begin
              cap_cnt <= cap_cnt + 2'd1;
              case (cap_cnt)
                2'd0:    word[7:0]   <= mem_din;
                2'd1:    word[15:8]  <= mem_din;
                2'd2:    word[23:16] <= mem_din;
                default: ;
              endcase
            end
            if (deliver) begin
              state   <= DONE;
              inst_ok <= 1'b1;
              inst_o  <= {mem_din, word};
              inst_pc <= base;
            end
`ifdef IF_PREFETCH_EN
            else if (last) begin
              pf_word  <= {mem_din, word};
              pf_pc    <= base;
              pf_valid <= 1'b1;
              state    <= IDLE;
            end else if (promote) begin
              state <= FETCH;
            end
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Directed self-checking bench for inst_fetch_port (default build, RAM_LAT=1).
module tb_inst_fetch_port;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rdy = 1'b1;
  logic          inst_fe = 1'b0;
  logic [AW-1:0] inst_fpc = '0;
  logic          mem_gnt = 1'b0;
  logic [7:0]    mem_din = '0;
  logic [31:0]   inst_o;
  logic          inst_ok;
  logic [AW-1:0] inst_pc;
  logic          mem_req;
  logic [AW-1:0] mem_a;
  logic          mem_wr;

  int tests = 0;
  int fails = 0;

  inst_fetch_port #(.ADDR_W(AW), .RAM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .inst_fe(inst_fe), .inst_fpc(inst_fpc),
    .inst_o(inst_o), .inst_ok(inst_ok), .inst_pc(inst_pc), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_a(mem_a), .mem_din(mem_din), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h1000: return 8'h13;
      32'h1001: return 8'h05;
      32'h1002, 32'h1003: return 8'h00;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {ram_byte(a + 32'd3), ram_byte(a + 32'd2), ram_byte(a + 32'd1), ram_byte(a)};
  endfunction

  // One-cycle-latency RAM, stalled together with the core by rdy.
  always @(posedge clk) if (rdy) mem_din <= ram_byte(mem_a);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full fetch of a, with the grant withheld for wait_n cycles of the request.
  task automatic burst(input logic [31:0] a, input int wait_n);
    for (int n = 0; n <= wait_n + 7; n++) begin
      int r;
      r = n - wait_n;
      @(negedge clk);
      inst_fe  = (r < 6);
      inst_fpc = a;
      mem_gnt  = (n >= wait_n);
      #1;
      chk("burst_mem_req", 32'(mem_req), 32'(r <= 5));
      chk("burst_mem_a", mem_a, (r >= 1 && r <= 4) ? a + 32'(r - 1) : 32'h0);
      chk("burst_inst_ok", 32'(inst_ok), 32'(r == 6));
      if (r == 6) begin
        chk("burst_inst_o", inst_o, exp_word(a));
        chk("burst_inst_pc", inst_pc, a);
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_inst_ok", 32'(inst_ok), 32'h0);
    chk("rst_inst_o", inst_o, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fetch: bytes 13 05 00 00 -> 0x00000513
    burst(32'h1000, 0);
    chk("hold_inst_o", inst_o, 32'h0000_0513);

    // Grant withheld 3 cycles
    burst(32'h2000, 3);

    // Address wraps past 2^32
    burst(32'hFFFF_FFFE, 0);

    // Redirect at T+3: 0x100 dropped, 0x200 delivered at T+11
    @(negedge clk);
    inst_fe = 1'b1; inst_fpc = 32'h100; mem_gnt = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 3) inst_fpc = 32'h200;
      if (n == 11) inst_fe = 1'b0;
      #1;
      chk("redir_inst_ok", 32'(inst_ok), 32'(n == 11));
      if (n == 4) begin
        chk("redir_mem_req", 32'(mem_req), 32'h0);
        chk("redir_mem_a", mem_a, 32'h0);
      end
      if (n == 6) chk("redir_new_a", mem_a, 32'h200);
      if (n == 11) begin
        chk("redir_inst_pc", inst_pc, 32'h200);
        chk("redir_inst_o", inst_o, exp_word(32'h200));
      end
    end

    // inst_fe drops mid-burst: no delivery
    @(negedge clk);
    inst_fe = 1'b1; inst_fpc = 32'h500;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 2) inst_fe = 1'b0;
      #1;
      chk("drop_inst_ok", 32'(inst_ok), 32'h0);
      if (n == 3) chk("drop_mem_req", 32'(mem_req), 32'h0);
    end

    // rdy low for 2 cycles inside FETCH
    @(negedge clk);
    inst_fe = 1'b1; inst_fpc = 32'h300;
    for (int n = 1; n <= 9; n++) begin
      logic [31:0] ea;
      @(negedge clk);
      rdy = !(n == 2 || n == 3);
      if (n == 8) inst_fe = 1'b0;
      case (n)
        1:       ea = 32'h300;
        2, 3, 4: ea = 32'h301;
        5:       ea = 32'h302;
        6:       ea = 32'h303;
        default: ea = 32'h0;
      endcase
      #1;
      chk("stall_mem_a", mem_a, ea);
      chk("stall_inst_ok", 32'(inst_ok), 32'(n == 8));
      if (n == 8) chk("stall_inst_o", inst_o, exp_word(32'h300));
    end
    rdy = 1'b1;

    // Reset in the middle of a burst
    @(negedge clk);
    inst_fe = 1'b1; inst_fpc = 32'h600;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 3) rst_n = 1'b0;
      if (n == 4) begin rst_n = 1'b1; inst_fe = 1'b0; end
      #1;
      if (n == 3) begin
        chk("mrst_mem_a", mem_a, 32'h0);
        chk("mrst_mem_req", 32'(mem_req), 32'h0);
        chk("mrst_inst_o", inst_o, 32'h0);
        chk("mrst_inst_pc", inst_pc, 32'h0);
      end
      chk("mrst_inst_ok", 32'(inst_ok), 32'h0);
    end

    // Recovery after reset
    burst(32'h0000_0040, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
